// File: rtl/xor_acc_pipe.sv
// xor_acc_pipe: XOR-reduces NIN operands per beat and either emits each
// beat's result directly or accumulates ACC_LEN beats into one frame result,
// behind a single-stage valid/ready output register with an even-parity bit.
module xor_acc_pipe #(
  parameter int WIDTH   = 8,
  parameter int NIN     = 3,
  parameter int ACC_LEN = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NIN*WIDTH-1:0] A,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic                 MODE,
  input  logic                 CLR,
  output logic [WIDTH-1:0]     Z,
  output logic                 ZP,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  inout  wire                  VDD,
  inout  wire                  VSS
);

  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);
  localparam bit SINGLE_BEAT = (ACC_LEN == 1);

  // Supply pins carry no logic; folded into a sink so they are not left dangling.
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fmode_q, fmode_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             zp_q, zp_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] beat_r;
  logic             accept;
  logic [WIDTH-1:0] base_acc;
  logic [CNT_W-1:0] base_cnt;
  logic             frame_start;
  logic             eff_mode;

  // Ready depends only on the output register and downstream, never on A/IN_VALID.
  assign IN_READY  = !out_valid_q || OUT_READY;
  assign accept    = IN_VALID && IN_READY;
  assign Z         = z_q;
  assign ZP        = zp_q;
  assign OUT_VALID = out_valid_q;

  // Beat value: bitwise XOR of all packed operands.
  always_comb begin
    beat_r = '0;
    for (int i = 0; i < NIN; i++) begin
      beat_r = beat_r ^ A[i*WIDTH +: WIDTH];
    end
  end

  // Next-state for frame state and output register; a same-edge CLR is applied before the beat.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    fmode_d     = fmode_q;
    z_d         = z_q;
    zp_d        = zp_q;
    out_valid_d = out_valid_q && !OUT_READY;

    base_acc    = CLR ? '0 : acc_q;
    base_cnt    = CLR ? '0 : cnt_q;
    frame_start = (base_cnt == '0);
    eff_mode    = frame_start ? MODE : fmode_q;

    if (CLR) begin
      acc_d = '0;
      cnt_d = '0;
    end

    if (accept) begin
      if (frame_start) begin
        fmode_d = MODE;
      end
      if (!eff_mode || SINGLE_BEAT) begin
        z_d         = beat_r;
        zp_d        = ^beat_r;
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end else if (base_cnt == CNT_LAST) begin
        z_d         = base_acc ^ beat_r;
        zp_d        = ^(base_acc ^ beat_r);
        out_valid_d = 1'b1;
        cnt_d       = '0;
        acc_d       = '0;
      end else begin
        acc_d = (frame_start ? '0 : base_acc) ^ beat_r;
        cnt_d = base_cnt + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous reset that discards any frame and pending result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      fmode_q     <= 1'b0;
      z_q         <= '0;
      zp_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      fmode_q     <= fmode_d;
      z_q         <= z_d;
      zp_q        <= zp_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_xor_acc_pipe.sv
// tb_xor_acc_pipe: directed scenarios plus randomized traffic, checked
// against a frame-level reference model built from a queue of beat values.
module tb_xor_acc_pipe;

  localparam int WIDTH   = 8;
  localparam int NIN     = 3;
  localparam int ACC_LEN = 4;

  logic                 clk;
  logic                 rst;
  logic [NIN*WIDTH-1:0] a;
  logic                 in_valid;
  logic                 in_ready;
  logic                 mode;
  logic                 clr;
  logic [WIDTH-1:0]     z;
  logic                 zp;
  logic                 out_valid;
  logic                 out_ready;
  wire                  vdd;
  wire                  vss;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: pending output plus the list of beats collected in the open frame.
  logic             m_ov;
  logic [WIDTH-1:0] m_z;
  logic             m_fmode;
  logic [WIDTH-1:0] frame_q[$];

  xor_acc_pipe #(.WIDTH(WIDTH), .NIN(NIN), .ACC_LEN(ACC_LEN)) dut (
    .CLK(clk), .RST(rst), .A(a), .IN_VALID(in_valid), .IN_READY(in_ready),
    .MODE(mode), .CLR(clr), .Z(z), .ZP(zp), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .VDD(vdd), .VSS(vss)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [WIDTH-1:0] frameXor();
    logic [WIDTH-1:0] acc;
    acc = '0;
    foreach (frame_q[i]) acc = acc ^ frame_q[i];
    return acc;
  endfunction

  task automatic modelReset();
    m_ov    = 1'b0;
    m_z     = '0;
    m_fmode = 1'b0;
    frame_q.delete();
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic modelEdge();
    logic             take;
    logic             next_ov;
    logic [WIDTH-1:0] r;
    take    = in_valid && (!m_ov || out_ready);
    next_ov = m_ov && !out_ready;
    r       = a[0 +: WIDTH] ^ a[WIDTH +: WIDTH] ^ a[2*WIDTH +: WIDTH];
    if (clr) frame_q.delete();
    if (take) begin
      if (frame_q.size() == 0) m_fmode = mode;
      if (!m_fmode || ACC_LEN == 1) begin
        m_z     = r;
        next_ov = 1'b1;
      end else begin
        frame_q.push_back(r);
        if (frame_q.size() == ACC_LEN) begin
          m_z     = frameXor();
          next_ov = 1'b1;
          frame_q.delete();
        end
      end
    end
    m_ov = next_ov;
  endtask

  // One clock cycle: drive inputs (beat value r split into random operands), check, clock, check.
  task automatic applyStimulus(input logic v, input logic md, input logic cl, input logic ordy, input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] a0, a1;
    a0 = WIDTH'($urandom);
    a1 = WIDTH'($urandom);
    a         = {r ^ a0 ^ a1, a1, a0};
    in_valid  = v;
    mode      = md;
    clr       = cl;
    out_ready = ordy;
    #1;
    checkOutput("in_ready", 32'(in_ready), 32'(!m_ov || ordy));
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("z", 32'(z), 32'(m_z));
    checkOutput("zp", 32'(zp), 32'(^m_z));
    checkOutput("out_valid", 32'(out_valid), 32'(m_ov));
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between edges, held across one edge with a beat offered.
  task automatic pulseReset();
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_z", 32'(z), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
    in_valid  = 1'b1;
    mode      = 1'b0;
    a         = 24'h123456;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_hold_ov", 32'(out_valid), 32'h0);
    checkOutput("rst_hold_z", 32'(z), 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    a         = '0;
    in_valid  = 1'b0;
    mode      = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    modelReset();
    #1;
    checkOutput("reset_z", 32'(z), 32'h0);
    checkOutput("reset_zp", 32'(zp), 32'h0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Per-beat XOR, exact operand pattern.
    a = {8'hAA, 8'h0F, 8'hF0}; in_valid = 1'b1; mode = 1'b0; clr = 1'b0; out_ready = 1'b1;
    @(posedge clk); modelEdge(); #1;
    checkOutput("d34_z", 32'(z), 32'h55);
    checkOutput("d34_zp", 32'(zp), 32'h0);
    checkOutput("d34_ov", 32'(out_valid), 32'h1);
    @(negedge clk);

    // Backpressure holds the result and stalls the next beat.
    applyStimulus(1, 0, 0, 0, 8'h55);
    applyStimulus(1, 0, 0, 0, 8'h01);
    checkOutput("d35_in_ready", 32'(in_ready), 32'h0);
    checkOutput("d35_hold_z", 32'(z), 32'h55);
    applyStimulus(1, 0, 0, 1, 8'h01);
    checkOutput("d35_z", 32'(z), 32'h01);
    checkOutput("d35_zp", 32'(zp), 32'h1);

    // Accumulate frame of four beats.
    applyStimulus(1, 1, 0, 1, 8'h01);
    applyStimulus(1, 1, 0, 1, 8'h02);
    applyStimulus(1, 1, 0, 1, 8'h04);
    checkOutput("d36_ov_beat3", 32'(out_valid), 32'h0);
    applyStimulus(1, 1, 0, 1, 8'h08);
    checkOutput("d36_z", 32'(z), 32'h0F);
    checkOutput("d36_ov", 32'(out_valid), 32'h1);

    // CLR discards a partial frame.
    applyStimulus(1, 1, 0, 1, 8'hFF);
    applyStimulus(1, 1, 0, 1, 8'hFF);
    applyStimulus(0, 1, 1, 1, 8'h00);
    applyStimulus(1, 1, 0, 1, 8'h10);
    applyStimulus(1, 1, 0, 1, 8'h20);
    applyStimulus(1, 1, 0, 1, 8'h40);
    checkOutput("d37_ov_beat3", 32'(out_valid), 32'h0);
    applyStimulus(1, 1, 0, 1, 8'h80);
    checkOutput("d37_z", 32'(z), 32'hF0);
    checkOutput("d37_zp", 32'(zp), 32'h0);

    // Asynchronous reset mid-frame.
    applyStimulus(1, 0, 0, 1, 8'h33);
    applyStimulus(1, 1, 0, 1, 8'h01);
    applyStimulus(1, 1, 0, 1, 8'h02);
    checkOutput("d38_pre_z", 32'(z), 32'h33);
    pulseReset();
    applyStimulus(1, 1, 0, 1, 8'h01);
    applyStimulus(1, 1, 0, 1, 8'h02);
    applyStimulus(1, 1, 0, 1, 8'h04);
    applyStimulus(1, 1, 0, 1, 8'h08);
    checkOutput("d38_z", 32'(z), 32'h0F);

    // MODE change mid-frame is ignored until the frame completes.
    applyStimulus(1, 1, 0, 1, 8'h01);
    applyStimulus(1, 0, 0, 1, 8'h02);
    checkOutput("d39_ov_beat2", 32'(out_valid), 32'h0);
    applyStimulus(1, 0, 0, 1, 8'h04);
    checkOutput("d39_ov_beat3", 32'(out_valid), 32'h0);
    applyStimulus(1, 0, 0, 1, 8'h08);
    checkOutput("d39_z", 32'(z), 32'h0F);
    applyStimulus(1, 0, 0, 1, 8'h77);
    checkOutput("d39_next_z", 32'(z), 32'h77);
    checkOutput("d39_next_ov", 32'(out_valid), 32'h1);

    // Randomized traffic with backpressure, clears and occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulseReset();
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                      WIDTH'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
